// File: rtl/multi_period_ctrl.sv
// ---------------------------------------------------------------------------
// multi_period_ctrl
//   Control unit for a classic multi-cycle MIPS-style datapath.
//   Moore FSM: every datapath control is decoded from the current state, with
//   mem_ready used only to qualify the FETCH register-write strobes. A
//   counter of retired (completed) instructions is kept alongside.
//
// Parameters
//   CNT_W           width of the retired-instruction counter (wraps)
//   HALT_ON_ILLEGAL 1: unknown opcode -> HALT, 0: unknown opcode is a NOP
//
// Ports
//   clk            clock, all state changes on its rising edge
//   rst            asynchronous, active-low reset
//   opcode[5:0]    instr[31:26] from the instruction register
//   mem_ready      memory completes the current access this cycle
//   pc_write .. alu_src_a   1-bit datapath controls
//   alu_src_b[1:0] ALU B mux select
//   alu_op[1:0]    00 add, 01 sub, 10 use funct field
//   pc_source[1:0] 00 ALU, 01 ALUOut, 10 jump target
//   state[3:0]     current state encoding
//   halted         high while in HALT
//   retired        count of completed instructions
// ---------------------------------------------------------------------------
module multi_period_ctrl #(
    parameter int CNT_W           = 16,
    parameter int HALT_ON_ILLEGAL = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       opcode,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic             i_or_d,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             mem_to_reg,
    output logic             reg_dst,
    output logic             reg_write,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic [1:0]       pc_source,
    output logic [3:0]       state,
    output logic             halted,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_EXEC     = 4'd6,
        S_R_WB     = 4'd7,
        S_BRANCH   = 4'd8,
        S_JUMP     = 4'd9,
        S_ADDI_EX  = 4'd10,
        S_ADDI_WB  = 4'd11,
        S_HALT     = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state_reg;
    logic [CNT_W-1:0] retired_reg;

    // Next-state and retire counting. The counter bumps on exactly the
    // edges that return to FETCH after completing an instruction; a reset
    // mid-instruction clears everything, so abandoned work is never counted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg   <= S_FETCH;
            retired_reg <= '0;
        end else begin
            case (state_reg)
                S_FETCH: begin
                    if (mem_ready) state_reg <= S_DECODE;
                end
                S_DECODE: begin
                    case (opcode)
                        OP_RTYPE:     state_reg <= S_EXEC;
                        OP_LW, OP_SW: state_reg <= S_MEM_ADDR;
                        OP_BEQ:       state_reg <= S_BRANCH;
                        OP_J:         state_reg <= S_JUMP;
                        OP_ADDI:      state_reg <= S_ADDI_EX;
                        default: begin
                            if (HALT_ON_ILLEGAL != 0) begin
                                state_reg <= S_HALT;
                            end else begin
                                // unknown opcode retires as a NOP
                                state_reg   <= S_FETCH;
                                retired_reg <= retired_reg + CNT_ONE;
                            end
                        end
                    endcase
                end
                S_MEM_ADDR: begin
                    // opcode is re-sampled here; anything but sw is a load
                    if (opcode == OP_SW) state_reg <= S_MEM_WR;
                    else                 state_reg <= S_MEM_RD;
                end
                S_MEM_RD: begin
                    if (mem_ready) state_reg <= S_MEM_WB;
                end
                S_MEM_WR: begin
                    if (mem_ready) begin
                        state_reg   <= S_FETCH;
                        retired_reg <= retired_reg + CNT_ONE;
                    end
                end
                S_EXEC:    state_reg <= S_R_WB;
                S_ADDI_EX: state_reg <= S_ADDI_WB;
                S_MEM_WB, S_R_WB, S_BRANCH, S_JUMP, S_ADDI_WB: begin
                    state_reg   <= S_FETCH;
                    retired_reg <= retired_reg + CNT_ONE;
                end
                S_HALT:  state_reg <= S_HALT;
                default: state_reg <= S_FETCH;
            endcase
        end
    end

    // Controls are decoded straight from the state register so that they are
    // valid in the very first FETCH cycle after reset and track mem_ready in
    // the same cycle (the FETCH write strobes depend on it).
    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        pc_source     = 2'b00;
        halted        = 1'b0;
        case (state_reg)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                // IR and PC only latch when the instruction word has arrived
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
            end
            S_MEM_ADDR, S_ADDI_EX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_MEM_RD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_MEM_WR: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
            end
            S_R_WB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = 2'b01;
                pc_write_cond = 1'b1;
                pc_source     = 2'b01;
            end
            S_JUMP: begin
                pc_write  = 1'b1;
                pc_source = 2'b10;
            end
            S_ADDI_WB: begin
                reg_write = 1'b1;
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: ;
        endcase
    end

    assign state   = state_reg;
    assign retired = retired_reg;

endmodule

// File: tb/tb_multi_period_ctrl.sv
// ---------------------------------------------------------------------------
// tb_multi_period_ctrl
//   Table-driven bench. Each table row is one clock cycle of stimulus plus
//   the state/retired values expected during that cycle. When a row is
//   driven its expectation is pushed to a scoreboard queue; a checker on the
//   falling edge pops and compares. A second instance (CNT_W=4, illegal
//   opcodes as NOPs) runs on the same stimulus and has its counter checked.
//   Async-reset corner cases are written out by hand at the end.
// ---------------------------------------------------------------------------
module tb_multi_period_ctrl;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ILL  = 6'b111111;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] opcode;
    logic       mem_ready;

    always #5 clk = ~clk;

    // main instance outputs
    logic        pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
    logic        mem_to_reg, reg_dst, reg_write, alu_src_a, halted;
    logic [1:0]  alu_src_b, alu_op, pc_source;
    logic [3:0]  state;
    logic [15:0] retired;

    // narrow-counter / NOP instance outputs
    logic        pc_write4, pc_write_cond4, i_or_d4, mem_read4, mem_write4, ir_write4;
    logic        mem_to_reg4, reg_dst4, reg_write4, alu_src_a4, halted4;
    logic [1:0]  alu_src_b4, alu_op4, pc_source4;
    logic [3:0]  state4;
    logic [3:0]  retired4;

    multi_period_ctrl #(.CNT_W(16), .HALT_ON_ILLEGAL(1)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .pc_source(pc_source), .state(state), .halted(halted), .retired(retired)
    );

    multi_period_ctrl #(.CNT_W(4), .HALT_ON_ILLEGAL(0)) dut4 (
        .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(pc_write4), .pc_write_cond(pc_write_cond4), .i_or_d(i_or_d4),
        .mem_read(mem_read4), .mem_write(mem_write4), .ir_write(ir_write4),
        .mem_to_reg(mem_to_reg4), .reg_dst(reg_dst4), .reg_write(reg_write4),
        .alu_src_a(alu_src_a4), .alu_src_b(alu_src_b4), .alu_op(alu_op4),
        .pc_source(pc_source4), .state(state4), .halted(halted4), .retired(retired4)
    );

    // {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
    //  mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
    //  pc_source, halted}
    logic [16:0] act_ctrl;
    assign act_ctrl = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                       mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
                       pc_source, halted};

    // Expected controls written out field by field from the per-state table.
    function automatic logic [16:0] exp_ctrl(input logic [3:0] st, input logic rdy);
        logic pw, pwc, iod, mr, mw, irw, m2r, rd, rw, asa, hlt;
        logic [1:0] asb, aop, psrc;
        pw = 0; pwc = 0; iod = 0; mr = 0; mw = 0; irw = 0; m2r = 0;
        rd = 0; rw = 0; asa = 0; hlt = 0; asb = 2'b00; aop = 2'b00; psrc = 2'b00;
        case (st)
            4'd0:  begin mr = 1; asb = 2'b01; irw = rdy; pw = rdy; end
            4'd1:  begin asb = 2'b11; end
            4'd2:  begin asa = 1; asb = 2'b10; end
            4'd3:  begin mr = 1; iod = 1; end
            4'd4:  begin rw = 1; m2r = 1; end
            4'd5:  begin mw = 1; iod = 1; end
            4'd6:  begin asa = 1; aop = 2'b10; end
            4'd7:  begin rw = 1; rd = 1; end
            4'd8:  begin asa = 1; aop = 2'b01; pwc = 1; psrc = 2'b01; end
            4'd9:  begin pw = 1; psrc = 2'b10; end
            4'd10: begin asa = 1; asb = 2'b10; end
            4'd11: begin rw = 1; end
            4'd12: begin hlt = 1; end
            default: ;
        endcase
        return {pw, pwc, iod, mr, mw, irw, m2r, rd, rw, asa, asb, aop, psrc, hlt};
    endfunction

    typedef struct {
        logic        rst;
        logic [5:0]  op;
        logic        rdy;
        logic [3:0]  st;
        logic [15:0] ret;
        logic [3:0]  ret4;
    } vec_t;

    typedef struct {
        int          idx;
        logic [3:0]  st;
        logic [16:0] ctrl;
        logic [15:0] ret;
        logic [3:0]  ret4;
    } exp_t;

    vec_t vecs[$];
    exp_t exp_q[$];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic add(input logic r, input logic [5:0] op, input logic rdy,
                       input logic [3:0] st, input int ret, input int ret4);
        vec_t v;
        v.rst = r; v.op = op; v.rdy = rdy; v.st = st;
        v.ret = 16'(ret); v.ret4 = 4'(ret4);
        vecs.push_back(v);
    endtask

    // Scoreboard checker: compare one expectation per falling edge.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk($sformatf("v%0d_state", e.idx), 32'(state), 32'(e.st));
            chk($sformatf("v%0d_ctrl", e.idx), 32'(act_ctrl), 32'(e.ctrl));
            chk($sformatf("v%0d_retired", e.idx), 32'(retired), 32'(e.ret));
            chk($sformatf("v%0d_retired4", e.idx), 32'(retired4), 32'(e.ret4));
            chk($sformatf("v%0d_rd_wr_excl", e.idx), 32'(mem_read & mem_write), 32'd0);
            $display("[TB] v%0d rst=%0b op=%b rdy=%0b state=%0d retired=%0d retired4=%0d",
                     e.idx, rst, opcode, mem_ready, state, retired, retired4);
        end
    end

    initial begin
        int r, r4;
        exp_t e;

        rst = 1'b0; opcode = OP_LW; mem_ready = 1'b1;

        // ---- table fill ----
        // lw, no stalls: 0,1,2,3,4 then back to 0
        add(0, OP_LW, 1, 0, 0, 0);
        add(1, OP_LW, 1, 0, 0, 0);
        add(1, OP_LW, 1, 1, 0, 0);
        add(1, OP_LW, 1, 2, 0, 0);
        add(1, OP_LW, 1, 3, 0, 0);
        add(1, OP_LW, 1, 4, 0, 0);
        // sw, three-cycle stall in MEM_WR
        add(1, OP_SW, 1, 0, 1, 1);
        add(1, OP_SW, 1, 1, 1, 1);
        add(1, OP_SW, 1, 2, 1, 1);
        add(1, OP_SW, 0, 5, 1, 1);
        add(1, OP_SW, 0, 5, 1, 1);
        add(1, OP_SW, 0, 5, 1, 1);
        add(1, OP_SW, 1, 5, 1, 1);
        // R-type with a two-cycle FETCH stall
        add(1, OP_R, 0, 0, 2, 2);
        add(1, OP_R, 0, 0, 2, 2);
        add(1, OP_R, 1, 0, 2, 2);
        add(1, OP_R, 1, 1, 2, 2);
        add(1, OP_R, 1, 6, 2, 2);
        add(1, OP_R, 1, 7, 2, 2);
        // addi
        add(1, OP_ADDI, 1, 0, 3, 3);
        add(1, OP_ADDI, 1, 1, 3, 3);
        add(1, OP_ADDI, 1, 10, 3, 3);
        add(1, OP_ADDI, 1, 11, 3, 3);
        // beq
        add(1, OP_BEQ, 1, 0, 4, 4);
        add(1, OP_BEQ, 1, 1, 4, 4);
        add(1, OP_BEQ, 1, 8, 4, 4);
        // j
        add(1, OP_J, 1, 0, 5, 5);
        add(1, OP_J, 1, 1, 5, 5);
        add(1, OP_J, 1, 9, 5, 5);
        // synchronous-looking reset row, then 16 jumps: 4-bit counter wraps
        add(0, OP_J, 1, 0, 0, 0);
        r = 0; r4 = 0;
        for (int k = 0; k < 16; k++) begin
            add(1, OP_J, 1, 0, r, r4);
            add(1, OP_J, 1, 1, r, r4);
            add(1, OP_J, 1, 9, r, r4);
            r++;
            r4 = (r4 + 1) % 16;
        end
        // illegal opcode: main halts; NOP instance keeps retiring every 2 cycles
        add(1, OP_ILL, 1, 0, r, r4);
        add(1, OP_ILL, 1, 1, r, r4);
        for (int h = 0; h < 10; h++) begin
            add(1, OP_ILL, 1, 12, r, (r4 + 1 + h / 2) % 16);
        end
        // reset out of HALT
        add(0, OP_ILL, 1, 0, 0, 0);
        add(1, OP_J, 1, 0, 0, 0);
        add(0, OP_LW, 1, 0, 0, 0);

        // ---- apply table ----
        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge clk);
            #1;
            rst       = vecs[i].rst;
            opcode    = vecs[i].op;
            mem_ready = vecs[i].rdy;
            e.idx  = i;
            e.st   = vecs[i].st;
            e.ctrl = exp_ctrl(vecs[i].st, vecs[i].rdy);
            e.ret  = vecs[i].ret;
            e.ret4 = vecs[i].ret4;
            exp_q.push_back(e);
        end
        @(negedge clk);
        #1;
        chk("sb_drain", 32'(exp_q.size()), 32'd0);

        // ---- hand sequence: async reset while stalled in MEM_RD ----
        @(posedge clk); #1;
        rst = 1'b1; opcode = OP_LW; mem_ready = 1'b1;   // FETCH
        @(posedge clk); #1;                              // DECODE
        @(posedge clk); #1;                              // MEM_ADDR
        @(posedge clk); #1;                              // MEM_RD
        mem_ready = 1'b0;
        @(posedge clk); #3;                              // still MEM_RD
        chk("hs_stall_state", 32'(state), 32'd3);
        chk("hs_stall_ctrl", 32'(act_ctrl), 32'(exp_ctrl(4'd3, 1'b0)));
        $display("[TB] hs stall state=%0d retired=%0d", state, retired);
        rst = 1'b0;
        #1;
        chk("hs_async_state", 32'(state), 32'd0);
        chk("hs_async_retired", 32'(retired), 32'd0);
        chk("hs_async_ctrl", 32'(act_ctrl), 32'(exp_ctrl(4'd0, 1'b0)));
        $display("[TB] hs async reset state=%0d retired=%0d", state, retired);
        @(posedge clk); #2;
        chk("hs_held_state", 32'(state), 32'd0);
        rst = 1'b1;
        @(negedge clk); #1;
        chk("hs_release_state", 32'(state), 32'd0);
        chk("hs_release_retired", 32'(retired), 32'd0);
        $display("[TB] hs release state=%0d retired=%0d", state, retired);
        mem_ready = 1'b1;
        @(posedge clk); #1;
        chk("hs_after_decode", 32'(state), 32'd1);
        $display("[TB] hs first edge state=%0d", state);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/multi_period_ctrl.md
MULTI_PERIOD_CTRL -- requirements
Module: multi_period_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 16: width of the retired-instruction counter.
REQ-002 SHALL have parameter HALT_ON_ILLEGAL, default 1: 1 sends an unknown opcode to HALT; 0 treats it as a NOP.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port opcode  input  6  instr[31:26] from the instruction register.
REQ-006 SHALL have port mem_ready  input  1  memory completes the current read or write this cycle.
REQ-007 SHALL have outputs pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a  output  1 each  standard multi-cycle datapath controls.
REQ-008 SHALL have outputs alu_src_b, alu_op, pc_source  output  2 each  ALU B mux, ALU op class (00 add, 01 sub, 10 funct), PC mux (00 ALU, 01 ALUOut, 10 jump).
REQ-009 SHALL have outputs state  output  4  current state encoding; halted  output  1  high in HALT.
REQ-010 SHALL have output retired  output  CNT_W  count of completed instructions.

Function
REQ-011 SHALL implement a Moore FSM with these encodings: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_RD=3, MEM_WB=4, MEM_WR=5, EXEC=6, R_WB=7, BRANCH=8, JUMP=9, ADDI_EX=10, ADDI_WB=11, HALT=12.
REQ-012 SHALL make all outputs functions of state and mem_ready only; any output not listed for a state SHALL be 0.
REQ-013 SHALL, in FETCH: assert mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00.
REQ-014 SHALL, in FETCH: assert ir_write and pc_write only in a cycle with mem_ready=1.
REQ-015 SHALL, in FETCH: stay in FETCH while mem_ready=0, otherwise go to DECODE.
REQ-016 SHALL, in DECODE: assert alu_src_a=0, alu_src_b=11, alu_op=00.
REQ-017 SHALL, in DECODE: branch on opcode: 000000 to EXEC; 100011 or 101011 to MEM_ADDR; 000100 to BRANCH; 000010 to JUMP; 001000 to ADDI_EX.
REQ-018 SHALL, in DECODE with any other opcode: go to HALT if HALT_ON_ILLEGAL=1, else go to FETCH and count it as retired.
REQ-019 SHALL, in MEM_ADDR: assert alu_src_a=1, alu_src_b=10, alu_op=00; next state is MEM_RD for lw, MEM_WR for sw, using opcode sampled in that cycle.
REQ-020 SHALL, in MEM_RD: assert mem_read=1, i_or_d=1; stay until mem_ready=1, then go to MEM_WB.
REQ-021 SHALL, in MEM_WB: assert reg_write=1, mem_to_reg=1, reg_dst=0; then go to FETCH.
REQ-022 SHALL, in MEM_WR: assert mem_write=1, i_or_d=1; stay until mem_ready=1, then go to FETCH.
REQ-023 SHALL, in EXEC: assert alu_src_a=1, alu_src_b=00, alu_op=10; go to R_WB.
REQ-024 SHALL, in R_WB: assert reg_write=1, reg_dst=1, mem_to_reg=0; go to FETCH.
REQ-025 SHALL, in BRANCH: assert alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01; go to FETCH.
REQ-026 SHALL, in JUMP: assert pc_write=1, pc_source=10; go to FETCH.
REQ-027 SHALL, in ADDI_EX: assert alu_src_a=1, alu_src_b=10, alu_op=00; go to ADDI_WB.
REQ-028 SHALL, in ADDI_WB: assert reg_write=1, reg_dst=0, mem_to_reg=0; go to FETCH.
REQ-029 SHALL, in HALT: assert halted=1, all other controls 0; remain in HALT until reset.
REQ-030 SHALL increment retired by 1 on every transition into FETCH from MEM_WB, MEM_WR (with mem_ready=1), R_WB, BRANCH, JUMP or ADDI_WB, and from DECODE for a NOP; it wraps modulo 2^CNT_W without saturation.
REQ-031 SHALL give cycle counts with mem_ready held at 1: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3; each memory-stall cycle adds 1.
REQ-032 SHALL never assert mem_read and mem_write together.

Reset
REQ-033 SHALL, while rst=0, force state=FETCH, retired=0, halted=0, independent of clk.
REQ-034 SHALL, on rst going low mid-instruction (including during a memory stall), abandon the instruction immediately, without counting it as retired.
REQ-035 SHALL, on the first rising edge after rst goes high, begin FETCH behaviour with REQ-013/014 outputs valid.

Verification
REQ-036 SHALL cover lw (100011) with mem_ready=1: states 0,1,2,3,4,0 over 5 cycles; retired 0->1; reg_write=1 and mem_to_reg=1 only in state 4.
REQ-037 SHALL cover sw with mem_ready low for 3 cycles in MEM_WR: state 5 held 4 cycles, mem_write=1 throughout, retired increments once.
REQ-038 SHALL cover FETCH stall with mem_ready=0 for 2 cycles: ir_write=0 and pc_write=0 during the stall; both 1 for exactly 1 cycle afterwards.
REQ-039 SHALL cover opcode 111111 with HALT_ON_ILLEGAL=1: state 12, halted=1, held 10 cycles; rst low then high returns to state 0 with retired=0.
REQ-040 SHALL cover CNT_W=4 with 16 consecutive j instructions: retired wraps to 0 after the 16th.
REQ-041 SHALL cover rst asserted low in state 3: state=0 at once without a clock edge; retired unchanged from 0 after release.
